spi_master_arbiter: RTL and testbench

SPI bus master that shares one SPI link between two requesters, each owning its own slave-select line. It runs one 8-bit full-duplex transfer at a time: MSB first, SCLK idle low, MOSI changed on the SCLK rising edge and both sides sampling on the falling edge. This is the timing the codebase's SPI slave expects, since that slave shifts on negedge sclk while ss is low. It sits between on-chip clients and the external serial bus, and arbitrates round-robin when both clients request at once.

---
 rtl/spi_master_arbiter.sv | 152 +++++++++++++++
 tb/tb_spi_master_arbiter.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_master_arbiter.sv
// Two-client SPI master: round-robin arbitration onto one shared 8-bit link,
// MSB first, SCLK idle low, MOSI launched on the rising edge, both sides sample on the falling edge.
module spi_master_arbiter #(
    parameter int CLK_DIV = 4,
    parameter int DATA_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0,
    input  logic              req1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              busy,
    output logic              done,
    output logic              done_id,
    output logic [DATA_W-1:0] rdata,
    output logic              sclk,
    output logic              mosi,
    input  logic              miso,
    output logic              ss0_n,
    output logic              ss1_n
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SHIFT_HI,
        SHIFT_LO,
        FINISH
    } state_t;

    state_t            state;
    logic [DIV_W-1:0]  div_cnt;
    logic [BIT_W-1:0]  bit_cnt;
    logic              owner;
    logic              last_srv;
    logic [DATA_W-1:0] tx_sr;
    logic [DATA_W-1:0] rx_sr;
    logic              win0;
    logic              win1;
    logic              phase_end;

    // The grant is decided in the IDLE cycle itself so a request pending during
    // FINISH is granted exactly one cycle after done.
    always_comb begin
        win0      = req0 && (!req1 || last_srv);
        win1      = req1 && (!req0 || !last_srv);
        gnt0      = (state == IDLE) && !rst && win0;
        gnt1      = (state == IDLE) && !rst && win1;
        busy      = (state != IDLE) || gnt0 || gnt1;
        phase_end = (div_cnt == DIV_LAST);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            div_cnt  <= '0;
            bit_cnt  <= '0;
            owner    <= 1'b0;
            last_srv <= 1'b1;
            sclk     <= 1'b0;
            mosi     <= 1'b0;
            ss0_n    <= 1'b1;
            ss1_n    <= 1'b1;
            done     <= 1'b0;
            done_id  <= 1'b0;
            rdata    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (win0 || win1) begin
                        state    <= SETUP;
                        owner    <= win1;
                        last_srv <= win1;
                        div_cnt  <= '0;
                        ss0_n    <= !win0;
                        ss1_n    <= !win1;
                        sclk     <= 1'b0;
                        mosi     <= 1'b0;
                    end
                end
                SETUP: begin
                    if (phase_end) begin
                        state   <= SHIFT_HI;
                        div_cnt <= '0;
                        bit_cnt <= '0;
                        sclk    <= 1'b1;
                        mosi    <= tx_sr[DATA_W-1];
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end
                SHIFT_HI: begin
                    if (phase_end) begin
                        state   <= SHIFT_LO;
                        div_cnt <= '0;
                        sclk    <= 1'b0;
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end
                SHIFT_LO: begin
                    if (phase_end) begin
                        div_cnt <= '0;
                        if (bit_cnt == BIT_LAST) begin
                            state   <= FINISH;
                            ss0_n   <= 1'b1;
                            ss1_n   <= 1'b1;
                            done    <= 1'b1;
                            done_id <= owner;
                            rdata   <= rx_sr;
                        end else begin
                            state   <= SHIFT_HI;
                            bit_cnt <= bit_cnt + 1'b1;
                            sclk    <= 1'b1;
                            mosi    <= tx_sr[DATA_W-1];
                        end
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end
                FINISH: begin
                    state <= IDLE;
                    done  <= 1'b0;
                    mosi  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Shift registers carry only data; the FSM decides when their contents matter.
    always_ff @(posedge clk) begin
        if (state == IDLE && (win0 || win1)) begin
            tx_sr <= win1 ? wdata1 : wdata0;
        end else if (state == SHIFT_HI && phase_end) begin
            tx_sr <= {tx_sr[DATA_W-2:0], 1'b0};
            rx_sr <= {rx_sr[DATA_W-2:0], miso};
        end
    end

endmodule

// File: tb/tb_spi_master_arbiter.sv
// Scoreboard bench for spi_master_arbiter: CLK_DIV=4 instance with two slave models,
// plus a CLK_DIV=1 instance with miso tied low.
module tb_spi_master_arbiter;

    typedef struct {
        bit         id;
        logic [7:0] wbyte;
        logic [7:0] rbyte;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    always begin
        @(posedge clk);
        cyc = cyc + 1;
    end

    // Instance A: CLK_DIV = 4
    logic       req0_a = 1'b0, req1_a = 1'b0;
    logic [7:0] wdata0_a = 8'h00, wdata1_a = 8'h00;
    logic       gnt0_a, gnt1_a, busy_a, done_a, done_id_a;
    logic [7:0] rdata_a;
    logic       sclk_a, mosi_a, miso_a, ss0_n_a, ss1_n_a;

    spi_master_arbiter #(.CLK_DIV(4), .DATA_W(8)) dut_a (
        .clk(clk), .rst(rst), .req0(req0_a), .req1(req1_a),
        .wdata0(wdata0_a), .wdata1(wdata1_a), .gnt0(gnt0_a), .gnt1(gnt1_a),
        .busy(busy_a), .done(done_a), .done_id(done_id_a), .rdata(rdata_a),
        .sclk(sclk_a), .mosi(mosi_a), .miso(miso_a), .ss0_n(ss0_n_a), .ss1_n(ss1_n_a)
    );

    // Instance B: CLK_DIV = 1
    logic       req0_b = 1'b0, req1_b = 1'b0;
    logic [7:0] wdata0_b = 8'h00, wdata1_b = 8'h00;
    logic       gnt0_b, gnt1_b, busy_b, done_b, done_id_b;
    logic [7:0] rdata_b;
    logic       sclk_b, mosi_b, ss0_n_b, ss1_n_b;
    logic       miso_b = 1'b0;

    spi_master_arbiter #(.CLK_DIV(1), .DATA_W(8)) dut_b (
        .clk(clk), .rst(rst), .req0(req0_b), .req1(req1_b),
        .wdata0(wdata0_b), .wdata1(wdata1_b), .gnt0(gnt0_b), .gnt1(gnt1_b),
        .busy(busy_b), .done(done_b), .done_id(done_id_b), .rdata(rdata_b),
        .sclk(sclk_b), .mosi(mosi_b), .miso(miso_b), .ss0_n(ss0_n_b), .ss1_n(ss1_n_b)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Slave models: load reply on ss fall, drive miso on sclk rise, sample mosi on sclk fall.
    logic [7:0] sb0 = 8'h3C, sb1 = 8'hC3;
    logic [7:0] s0_tx = 8'h00, s1_tx = 8'h00, s0_rx = 8'h00, s1_rx = 8'h00, rx_b = 8'h00;
    logic       s0_bit = 1'b0, s1_bit = 1'b0;

    assign miso_a = !ss0_n_a ? s0_bit : (!ss1_n_a ? s1_bit : 1'b0);

    always begin
        @(negedge ss0_n_a);
        s0_tx = sb0;
    end
    always begin
        @(negedge ss1_n_a);
        s1_tx = sb1;
    end
    always begin
        @(posedge sclk_a);
        if (!ss0_n_a) begin
            s0_bit = s0_tx[7];
            s0_tx  = {s0_tx[6:0], 1'b0};
        end
        if (!ss1_n_a) begin
            s1_bit = s1_tx[7];
            s1_tx  = {s1_tx[6:0], 1'b0};
        end
    end
    always begin
        @(negedge sclk_a);
        if (!ss0_n_a) s0_rx = {s0_rx[6:0], mosi_a};
        if (!ss1_n_a) s1_rx = {s1_rx[6:0], mosi_a};
    end
    always begin
        @(negedge sclk_b);
        if (!ss1_n_b) rx_b = {rx_b[6:0], mosi_b};
    end

    exp_t qa[$];
    exp_t qb[$];
    int   n_gnt_a = 0, n_done_a = 0, gnt_cyc_a = 0, done_cyc_a = 0;
    int   hi_run = 1, excl_err = 0, own_err = 0, gap_err = 0;
    bit   inflight = 1'b0, own = 1'b0;
    int   n_gnt_b = 0, n_done_b = 0, gnt_cyc_b = 0, pulses_b = 0;
    logic sclk_prev_b = 1'b0;

    // Monitor A
    always begin
        exp_t e;
        @(negedge clk);
        if (rst) begin
            inflight = 1'b0;
        end else begin
            if (ss0_n_a && ss1_n_a) hi_run++;
            else hi_run = 0;
            if (!ss0_n_a && !ss1_n_a) excl_err++;
            if (inflight && (own ? !ss0_n_a : !ss1_n_a)) own_err++;
            if (gnt0_a || gnt1_a) begin
                if (gnt0_a && gnt1_a) excl_err++;
                if (hi_run == 0) gap_err++;
                gnt_cyc_a = cyc;
                own       = gnt1_a;
                inflight  = 1'b1;
                n_gnt_a++;
                if (qa.size() > 0) check_eq("gnt_id", gnt1_a, qa[0].id);
                else check_eq("gnt_unexpected", qa.size(), 1);
            end
            if (done_a) begin
                n_done_a++;
                done_cyc_a = cyc;
                inflight   = 1'b0;
                if (qa.size() == 0) begin
                    check_eq("done_unexpected", qa.size(), 1);
                end else begin
                    e = qa.pop_front();
                    check_eq("done_id", done_id_a, e.id);
                    check_eq("rdata", rdata_a, e.rbyte);
                    check_eq("mosi_byte", e.id ? s1_rx : s0_rx, e.wbyte);
                    check_eq("done_latency", cyc - gnt_cyc_a, 69);
                end
            end
        end
    end

    // Monitor B
    always begin
        exp_t e;
        @(negedge clk);
        if (!rst) begin
            if (sclk_b && !sclk_prev_b) pulses_b++;
            sclk_prev_b = sclk_b;
            if (gnt0_b || gnt1_b) begin
                gnt_cyc_b = cyc;
                pulses_b  = 0;
                n_gnt_b++;
            end
            if (done_b) begin
                n_done_b++;
                if (qb.size() == 0) begin
                    check_eq("b_done_unexpected", qb.size(), 1);
                end else begin
                    e = qb.pop_front();
                    check_eq("b_done_id", done_id_b, e.id);
                    check_eq("b_rdata", rdata_b, e.rbyte);
                    check_eq("b_mosi_byte", rx_b, e.wbyte);
                    check_eq("b_done_latency", cyc - gnt_cyc_b, 18);
                    check_eq("b_sclk_pulses", pulses_b, 8);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_gnt_a(input int target);
        int k = 0;
        while (n_gnt_a < target && k < 400) begin
            tick();
            k++;
        end
        check_eq("gnt_a_timeout", n_gnt_a >= target, 1);
    endtask

    task automatic wait_idle_a();
        int k = 0;
        while ((qa.size() != 0 || busy_a) && k < 800) begin
            tick();
            k++;
        end
        check_eq("idle_a_timeout", qa.size(), 0);
    endtask

    function automatic exp_t mk(input bit id, input logic [7:0] w, input logic [7:0] r);
        exp_t e;
        e.id = id;
        e.wbyte = w;
        e.rbyte = r;
        return e;
    endfunction

    initial begin
        int saved;
        int k;
        repeat (3) tick();
        check_eq("rst_sclk", sclk_a, 0);
        check_eq("rst_mosi", mosi_a, 0);
        check_eq("rst_ss0_n", ss0_n_a, 1);
        check_eq("rst_ss1_n", ss1_n_a, 1);
        check_eq("rst_gnt", {gnt1_a, gnt0_a}, 0);
        check_eq("rst_busy", busy_a, 0);
        check_eq("rst_done", done_a, 0);
        check_eq("rst_done_id", done_id_a, 0);
        check_eq("rst_rdata", rdata_a, 8'h00);
        rst = 1'b0;
        tick();

        // Single req0, 0xA5 out, 0x3C back
        qa.push_back(mk(1'b0, 8'hA5, 8'h3C));
        wdata0_a = 8'hA5;
        req0_a = 1'b1;
        wait_gnt_a(n_gnt_a + 1);
        req0_a = 1'b0;
        wait_idle_a();

        // req1 arriving mid-transfer is granted at done+1
        qa.push_back(mk(1'b0, 8'h5A, 8'h3C));
        wdata0_a = 8'h5A;
        req0_a = 1'b1;
        wait_gnt_a(n_gnt_a + 1);
        req0_a = 1'b0;
        repeat (10) tick();
        qa.push_back(mk(1'b1, 8'h96, 8'hC3));
        wdata1_a = 8'h96;
        req1_a = 1'b1;
        wait_gnt_a(n_gnt_a + 1);
        req1_a = 1'b0;
        check_eq("gnt1_at_done_plus1", gnt_cyc_a - done_cyc_a, 1);
        wait_idle_a();

        // Both held for four transfers: order 0,1,0,1
        wdata0_a = 8'h11;
        wdata1_a = 8'h22;
        qa.push_back(mk(1'b0, 8'h11, 8'h3C));
        qa.push_back(mk(1'b1, 8'h22, 8'hC3));
        qa.push_back(mk(1'b0, 8'h11, 8'h3C));
        qa.push_back(mk(1'b1, 8'h22, 8'hC3));
        req0_a = 1'b1;
        req1_a = 1'b1;
        wait_gnt_a(n_gnt_a + 4);
        req0_a = 1'b0;
        req1_a = 1'b0;
        wait_idle_a();

        // wdata changes the cycle after grant; captured byte must survive
        qa.push_back(mk(1'b0, 8'h81, 8'h3C));
        wdata0_a = 8'h81;
        req0_a = 1'b1;
        wait_gnt_a(n_gnt_a + 1);
        req0_a = 1'b0;
        wdata0_a = 8'h00;
        wait_idle_a();

        // Reset during SHIFT_HI of bit 4
        qa.push_back(mk(1'b0, 8'hC7, 8'h3C));
        wdata0_a = 8'hC7;
        req0_a = 1'b1;
        wait_gnt_a(n_gnt_a + 1);
        req0_a = 1'b0;
        k = 0;
        while (cyc < gnt_cyc_a + 38 && k < 100) begin
            tick();
            k++;
        end
        check_eq("sclk_hi_before_rst", sclk_a, 1);
        rst = 1'b1;
        #1;
        check_eq("arst_sclk", sclk_a, 0);
        check_eq("arst_ss0_n", ss0_n_a, 1);
        check_eq("arst_done", done_a, 0);
        check_eq("arst_busy", busy_a, 0);
        qa.delete();
        tick();
        rst = 1'b0;
        saved = n_done_a;
        repeat (80) tick();
        check_eq("no_done_after_rst", n_done_a, saved);

        // Tie after reset: req0 wins first
        wdata0_a = 8'h3E;
        wdata1_a = 8'hE1;
        qa.push_back(mk(1'b0, 8'h3E, 8'h3C));
        qa.push_back(mk(1'b1, 8'hE1, 8'hC3));
        req0_a = 1'b1;
        req1_a = 1'b1;
        wait_gnt_a(n_gnt_a + 2);
        req0_a = 1'b0;
        req1_a = 1'b0;
        wait_idle_a();

        // CLK_DIV = 1, req1 alone, 0xFF out, miso low
        qb.push_back(mk(1'b1, 8'hFF, 8'h00));
        wdata1_b = 8'hFF;
        req1_b = 1'b1;
        k = 0;
        while (n_gnt_b < 1 && k < 100) begin
            tick();
            k++;
        end
        req1_b = 1'b0;
        k = 0;
        while ((qb.size() != 0 || busy_b) && k < 100) begin
            tick();
            k++;
        end
        check_eq("idle_b_timeout", qb.size(), 0);
        check_eq("b_ss0_idle", ss0_n_b, 1);

        check_eq("ss_exclusive", excl_err, 0);
        check_eq("ss_owner_only", own_err, 0);
        check_eq("ss_gap", gap_err, 0);
        check_eq("done_count_a", n_done_a, 10);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
